piso_bit_serializer: RTL and testbench
======================================

// Module: piso_bit_serializer
// PURPOSE
//  Parallel-in/serial-out stage that feeds the single-bit Din input of the serial
//  pattern-detector FSM. Accepts WIDTH-bit words over a valid/ready handshake and
//  shifts them out one bit per Clock, with a qualifying valid flag. Optional idle
//  gap between words, driven as 0. Supports back-to-back streaming when the gap is 0.
// PARAMETERS
//  WIDTH       8  word width in bits; legal range 2..32
//  MSB_FIRST   1  1: bit WIDTH-1 is sent first; 0: bit 0 is sent first
//  GAP_CYCLES  0  idle cycles (SerOut=0, SerValid=0) inserted after each word; 0..15
// PORTS
//  Clock      in   1      rising-edge clock
//  Reset      in   1      asynchronous, active-low reset
//  DataIn     in   WIDTH  parallel word; sampled only on an accept edge
//  DataValid  in   1      upstream has a word on DataIn
//  DataReady  out  1      block can accept a word this cycle (combinational from state)
//  SerOut     out  1      serial bit, registered; connects to detector Din
//  SerValid   out  1      SerOut carries a payload bit this cycle
//  Busy       out  1      1 in SHIFT or GAP
//  WordDone   out  1      1-cycle pulse, coincident with the last bit of a word
// BEHAVIOUR
//  Reset (Reset=0, asynchronous): state=IDLE, shift reg=0, counters=0, SerOut=0,
//   SerValid=0, Busy=0, WordDone=0, DataReady=0 while Reset is low.
//  Accept: a word is taken on a rising edge with DataValid=1 and DataReady=1. DataIn is
//   loaded into the shift register. No accept happens when DataReady=0; DataIn is ignored.
//  DataReady=1 under these conditions:
//   (a) in IDLE;
//   (b) on the last SHIFT bit when GAP_CYCLES=0;
//   (c) on the last GAP cycle.
//  Latency: accept at edge k; bit 0 of the word (first bit per MSB_FIRST) on SerOut
//   after edge k; last bit after edge k+WIDTH-1.
//  States:
//   IDLE : SerOut=0, SerValid=0. On accept -> SHIFT, bit counter=0.
//   SHIFT: SerValid=1, SerOut=current bit, counter +1 per edge.
//    At counter=WIDTH-1: WordDone=1.
//    Next edge: -> GAP if GAP_CYCLES>0.
//    Otherwise, with accept -> SHIFT (new word, counter=0), no bubble.
//    Otherwise -> IDLE.
//   GAP  : SerOut=0, SerValid=0, gap counter counts to GAP_CYCLES-1.
//    Then: with accept -> SHIFT; without accept -> IDLE.
//  Counter widths: $clog2(WIDTH) bits and $clog2(GAP_CYCLES+1) bits (min 1).
//   No wrap beyond the terminal count; terminal compare is exact.
//  Illegal state encoding -> IDLE on the next edge, outputs as IDLE.
//  SerOut is forced to 0 whenever SerValid=0, so the detector sees 0 between words.
//  Reset mid-word: the in-flight word is dropped and SerOut/SerValid go low immediately.
//   After release, the block restarts in IDLE; no partial word is resumed.
//  DataValid may drop without an accept; there is no requirement to hold it.
//  Words accepted while Busy are impossible (DataReady=0), except in cases (b) and (c).
// TESTING
//  1 WIDTH=8, MSB_FIRST=1: accept 8'hA5 -> SerOut 1,0,1,0,0,1,0,1 on edges k..k+7,
//    SerValid high 8 cycles, WordDone on the 8th bit, then IDLE.
//  2 MSB_FIRST=0, accept 8'h05 -> SerOut 1,0,1,0,0,0,0,0. The detector driven by SerOut
//    asserts Dout while the third bit (1) is present.
//  3 GAP_CYCLES=0, DataValid held high with 8'hFF then 8'h00 -> 16 contiguous SerValid
//    cycles, DataReady high only on bit 8 and in IDLE, no bubble between words.
//  4 GAP_CYCLES=2, two words back-to-back -> exactly 2 cycles of SerOut=0 and SerValid=0
//    between them. Second accept on the last GAP cycle.
//  5 Reset pulsed low mid-bit-3 of 8'hC3 -> SerOut/SerValid 0 asynchronously, IDLE after
//    release. The next word 8'h81 is serialized cleanly with no residue of 8'hC3.
//  6 DataValid high while Busy (GAP=2) -> no accept until DataReady. DataIn changes
//    during SHIFT do not affect the bits being shifted out.

Source files
------------

// File: rtl/piso_bit_serializer.sv
// Parallel-in/serial-out stage: takes WIDTH-bit words over valid/ready and shifts
// them out one bit per Clock, with an optional zero-filled gap after each word.
module piso_bit_serializer #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 0
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] DataIn,
  input  logic             DataValid,
  output logic             DataReady,
  output logic             SerOut,
  output logic             SerValid,
  output logic             Busy,
  output logic             WordDone
);

  // state | meaning
  // IDLE  | no word in flight, ready for a new word
  // SHIFT | presenting payload bits, bit_cnt = index of the bit on SerOut
  // GAP   | zero-filled idle cycles after a word, gap_cnt = gap cycle index
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  localparam int CW = $clog2(WIDTH);
  localparam int GW = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  localparam logic [CW-1:0] BIT_LAST   = CW'(WIDTH - 1);
  localparam logic [CW-1:0] BIT_PENULT = CW'(WIDTH - 2);
  localparam logic [GW-1:0] GAP_LAST   = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    bit_cnt;
  logic [GW-1:0]    gap_cnt;
  logic             ser_valid;
  logic             word_done;
  logic             ready_raw;
  logic             accept;
  logic             cur_bit;

  always_comb begin
    ready_raw = 1'b0;
    case (state)
      S_IDLE:  ready_raw = 1'b1;
      S_SHIFT: ready_raw = (GAP_CYCLES == 0) && (bit_cnt == BIT_LAST);
      S_GAP:   ready_raw = (gap_cnt == GAP_LAST);
      default: ready_raw = 1'b0;
    endcase
  end

  // Ready is held low for the whole time Reset is asserted, even though state is IDLE.
  assign DataReady = Reset & ready_raw;
  assign accept    = DataValid & DataReady;

  // The bit on the line always sits at the outgoing end of the shift register.
  assign cur_bit = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state     <= S_IDLE;
      shreg     <= '0;
      bit_cnt   <= '0;
      gap_cnt   <= '0;
      ser_valid <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= 1'b0;
      if (accept) begin
        state     <= S_SHIFT;
        shreg     <= DataIn;
        bit_cnt   <= '0;
        gap_cnt   <= '0;
        ser_valid <= 1'b1;
      end else begin
        case (state)
          S_IDLE: begin
            ser_valid <= 1'b0;
          end
          S_SHIFT: begin
            if (bit_cnt == BIT_LAST) begin
              state     <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
              shreg     <= '0;
              bit_cnt   <= '0;
              gap_cnt   <= '0;
              ser_valid <= 1'b0;
            end else begin
              shreg     <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0}
                                            : {1'b0, shreg[WIDTH-1:1]};
              bit_cnt   <= bit_cnt + 1'b1;
              word_done <= (bit_cnt == BIT_PENULT);
            end
          end
          S_GAP: begin
            if (gap_cnt == GAP_LAST) begin
              state   <= S_IDLE;
              gap_cnt <= '0;
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
          default: begin
            state     <= S_IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            ser_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign SerValid = ser_valid;
  assign SerOut   = ser_valid & cur_bit;
  assign WordDone = word_done;
  assign Busy     = (state == S_SHIFT) || (state == S_GAP);

endmodule

// File: tb/tb_piso_bit_serializer.sv
// Bench for piso_bit_serializer: three instances (MSB/gap0, LSB/gap0, MSB/gap2)
// checked cycle by cycle against a queue-of-expected-line-cycles model.
module tb_piso_bit_serializer;

  logic Clock = 1'b0;
  always #5 Clock = ~Clock;

  logic       Reset;
  logic [7:0] din [3];
  logic       dv  [3];
  logic       dr  [3];
  logic       so  [3];
  logic       sv  [3];
  logic       bsy [3];
  logic       wd  [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    piso_bit_serializer #(
      .WIDTH      (8),
      .MSB_FIRST  ((g == 1) ? 0 : 1),
      .GAP_CYCLES ((g == 2) ? 2 : 0)
    ) u_dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .DataIn    (din[g]),
      .DataValid (dv[g]),
      .DataReady (dr[g]),
      .SerOut    (so[g]),
      .SerValid  (sv[g]),
      .Busy      (bsy[g]),
      .WordDone  (wd[g])
    );
  end

  // One entry per future line cycle: what SerValid/SerOut/WordDone must show.
  typedef struct packed {
    logic v;
    logic b;
    logic d;
  } ent_t;

  ent_t mq [3][$];
  logic ev [3], eb [3], ed [3], er [3], eby [3];
  bit   acc_last [3];
  int   checks = 0;
  int   errors = 0;

  function automatic bit msb_of(int g);
    return g != 1;
  endfunction

  function automatic int gap_of(int g);
    return (g == 2) ? 2 : 0;
  endfunction

  function automatic void compute_exp();
    for (int g = 0; g < 3; g++) begin
      if (mq[g].size() > 0) begin
        ev[g] = mq[g][0].v;
        eb[g] = mq[g][0].b;
        ed[g] = mq[g][0].d;
      end else begin
        ev[g] = 1'b0;
        eb[g] = 1'b0;
        ed[g] = 1'b0;
      end
      er[g]  = Reset && (mq[g].size() <= 1);
      eby[g] = Reset && (mq[g].size() > 0);
    end
  endfunction

  function automatic void flush_model();
    for (int g = 0; g < 3; g++) mq[g].delete();
    compute_exp();
  endfunction

  // Advance one clock: decide accepts from the model, apply the edge, sample at +1.
  task automatic step();
    bit         acc [3];
    logic [7:0] w   [3];
    ent_t       e;
    for (int g = 0; g < 3; g++) begin
      acc[g] = Reset && dv[g] && (mq[g].size() <= 1);
      w[g]   = din[g];
    end
    @(posedge Clock);
    for (int g = 0; g < 3; g++) begin
      if (!Reset) begin
        mq[g].delete();
      end else begin
        if (mq[g].size() > 0) void'(mq[g].pop_front());
        if (acc[g]) begin
          for (int i = 0; i < 8; i++) begin
            e.v = 1'b1;
            e.b = msb_of(g) ? w[g][7-i] : w[g][i];
            e.d = (i == 7);
            mq[g].push_back(e);
          end
          for (int i = 0; i < gap_of(g); i++) begin
            e = '0;
            mq[g].push_back(e);
          end
        end
      end
      acc_last[g] = acc[g];
    end
    #1;
    compute_exp();
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    for (int g = 0; g < 3; g++) begin
      din[g] = 8'h00;
      dv[g]  = 1'b1;
    end
    repeat (3) @(posedge Clock);
    #1;
    flush_model();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== 5'b00000) begin
        errors++;
        $display("FAIL reset_hold dut%0d: got v/b/d/r/busy=%b%b%b%b%b want 00000",
                 g, sv[g], so[g], wd[g], dr[g], bsy[g]);
      end
      dv[g] = 1'b0;
    end
    @(negedge Clock);
    Reset = 1'b1;
    #1;
    compute_exp();
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
        errors++;
        $display("FAIL reset_release dut%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                 g, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
      end
    end
  endtask

  task automatic test_msb_a5();
    logic [7:0] s = '0;
    int         n = 0;
    din[0] = 8'hA5;
    dv[0]  = 1'b1;
    step();
    dv[0] = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL msb_a5 dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
      if (sv[0]) begin
        s = {s[6:0], so[0]};
        n++;
      end
    end
    checks++;
    if (s !== 8'hA5 || n != 8) begin
      errors++;
      $display("FAIL msb_a5_stream: got %h over %0d bits want a5 over 8 bits", s, n);
    end
  endtask

  task automatic test_lsb_05();
    logic [7:0] s = '0;
    int         n = 0;
    din[1] = 8'h05;
    dv[1]  = 1'b1;
    step();
    dv[1] = 1'b0;
    for (int c = 0; c < 11; c++) begin
      if (c > 0) step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL lsb_05 dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
      if (sv[1] && n < 8) begin
        s[n] = so[1];
        n++;
      end
    end
    checks++;
    if (s !== 8'h05 || n != 8) begin
      errors++;
      $display("FAIL lsb_05_stream: got %h over %0d bits want 05 over 8 bits", s, n);
    end
  endtask

  task automatic test_back_to_back();
    int words = 0, run = 0, max_run = 0, rdy_in_run = 0;
    din[0] = 8'hFF;
    dv[0]  = 1'b1;
    for (int c = 0; c < 22; c++) begin
      step();
      if (acc_last[0]) begin
        words++;
        din[0] = 8'h00;
        if (words == 2) dv[0] = 1'b0;
      end
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL back_to_back dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
      if (sv[0]) begin
        run++;
        if (run <= 15 && dr[0]) rdy_in_run++;
      end else begin
        run = 0;
      end
      if (run > max_run) max_run = run;
    end
    checks++;
    if (max_run != 16 || rdy_in_run != 1) begin
      errors++;
      $display("FAIL back_to_back_run: got run %0d ready %0d want run 16 ready 1",
               max_run, rdy_in_run);
    end
  endtask

  task automatic test_gap();
    int  gap_len = 0, rises = 0;
    bit  seen_fall = 0;
    logic prev_v = 1'b0;
    din[2] = 8'h5A;
    dv[2]  = 1'b1;
    for (int c = 0; c < 26; c++) begin
      step();
      if (acc_last[2]) begin
        din[2] = 8'h3C;
        if (rises == 1) dv[2] = 1'b0;
        rises++;
      end
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL gap dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
      if (prev_v && !sv[2]) seen_fall = 1;
      if (seen_fall && !sv[2] && rises == 1) gap_len++;
      if (seen_fall && !sv[2] && so[2]) gap_len = 99;
      prev_v = sv[2];
    end
    checks++;
    if (gap_len != 2) begin
      errors++;
      $display("FAIL gap_len: got %0d idle cycles between words want 2", gap_len);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] s = '0;
    int         n = 0;
    din[0] = 8'hC3;
    dv[0]  = 1'b1;
    step();
    dv[0] = 1'b0;
    repeat (3) step();
    #2;
    Reset = 1'b0;
    #1;
    checks++;
    if ({sv[0], so[0], dr[0], bsy[0]} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid_async: got v/b/r/busy=%b%b%b%b want 0000",
               sv[0], so[0], dr[0], bsy[0]);
    end
    flush_model();
    @(negedge Clock);
    Reset = 1'b1;
    din[0] = 8'h81;
    dv[0]  = 1'b1;
    step();
    dv[0] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (c > 0) step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL reset_mid dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
      if (sv[0]) begin
        s = {s[6:0], so[0]};
        n++;
      end
    end
    checks++;
    if (s !== 8'h81 || n != 8) begin
      errors++;
      $display("FAIL reset_mid_stream: got %h over %0d bits want 81 over 8 bits", s, n);
    end
  endtask

  task automatic test_busy_hold();
    dv[2] = 1'b1;
    for (int c = 0; c < 40; c++) begin
      din[2] = 8'($urandom);
      step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL busy_hold dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
    end
    dv[2] = 1'b0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int g = 0; g < 3; g++) begin
        din[g] = 8'($urandom);
        dv[g]  = ($urandom_range(0, 9) < 6);
      end
      step();
      for (int g = 0; g < 3; g++) begin
        checks++;
        if ({sv[g], so[g], wd[g], dr[g], bsy[g]} !== {ev[g], eb[g], ed[g], er[g], eby[g]}) begin
          errors++;
          $display("FAIL random dut%0d cyc%0d: got v/b/d/r/busy=%b%b%b%b%b want %b%b%b%b%b",
                   g, c, sv[g], so[g], wd[g], dr[g], bsy[g], ev[g], eb[g], ed[g], er[g], eby[g]);
        end
      end
    end
    for (int g = 0; g < 3; g++) dv[g] = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_msb_a5();
    test_lsb_05();
    test_back_to_back();
    test_gap();
    test_reset_mid();
    test_busy_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
